// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards against the instruction already in EXE and inserts a single bubble for each one.
// Flushes on a taken branch and holds on a downstream stall.
// Counts load-use bubbles in a saturating counter.
module id_ex_hazard_reg #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned AluOpWidth   = 4,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ID_Valid,
    input  logic [RegAddrWidth-1:0] ID_RS1,
    input  logic [RegAddrWidth-1:0] ID_RS2,
    input  logic                    ID_Uses_RS1,
    input  logic                    ID_Uses_RS2,
    input  logic [RegAddrWidth-1:0] ID_RD,
    input  logic                    ID_Reg_File_EN,
    input  logic                    ID_Mem_Read_EN,
    input  logic                    ID_Mem_Write_EN,
    input  logic [AluOpWidth-1:0]   ID_ALU_Op,
    input  logic [DataWidth-1:0]    ID_Operand_A,
    input  logic [DataWidth-1:0]    ID_Operand_B,
    input  logic [DataWidth-1:0]    ID_Imm,
    input  logic                    Flush_EXE,
    input  logic                    Stall_In,
    output logic [RegAddrWidth-1:0] ID_EX_RS1,
    output logic [RegAddrWidth-1:0] ID_EX_RS2,
    output logic [RegAddrWidth-1:0] WriteBack_reg_EXE_stage,
    output logic                    Reg_File_EN_EXE_stage,
    output logic                    Mem_Read_EN_EXE_stage,
    output logic                    Mem_Write_EN_EXE_stage,
    output logic [AluOpWidth-1:0]   EX_ALU_Op,
    output logic [DataWidth-1:0]    EX_Operand_A,
    output logic [DataWidth-1:0]    EX_Operand_B,
    output logic [DataWidth-1:0]    EX_Imm,
    output logic                    EX_Valid,
    output logic                    Stall_IF_ID,
    output logic [CntWidth-1:0]     Stall_Count
);

    // What the EXE slot does at the next edge
    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_BUBBLE
    } act_e;

    act_e act;
    logic load_use;
    logic count_en;

    logic [RegAddrWidth-1:0] rs1_q, rs1_d;
    logic [RegAddrWidth-1:0] rs2_q, rs2_d;
    logic [RegAddrWidth-1:0] rd_q, rd_d;
    logic                    rf_en_q, rf_en_d;
    logic                    mem_rd_q, mem_rd_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [AluOpWidth-1:0]   alu_op_q, alu_op_d;
    logic [DataWidth-1:0]    op_a_q, op_a_d;
    logic [DataWidth-1:0]    op_b_q, op_b_d;
    logic [DataWidth-1:0]    imm_q, imm_d;
    logic                    valid_q, valid_d;
    logic [CntWidth-1:0]     stall_cnt_q, stall_cnt_d;

    // Load in EXE whose destination (non-x0) is read by the valid ID instruction
    always_comb begin
        load_use = valid_q & mem_rd_q & ID_Valid & (rd_q != '0)
                 & ((ID_Uses_RS1 & (ID_RS1 == rd_q)) | (ID_Uses_RS2 & (ID_RS2 == rd_q)));
    end

    // Edge action by priority: flush, external stall, load-use, then normal capture
    always_comb begin
        act      = ACT_CAPTURE;
        count_en = 1'b0;
        if (Flush_EXE) begin
            act = ACT_BUBBLE;
        end else if (Stall_In) begin
            act = ACT_HOLD;
        end else if (load_use) begin
            act      = ACT_BUBBLE;
            count_en = 1'b1;
        end
        Stall_IF_ID = ~Flush_EXE & (Stall_In | load_use);
    end

    // Next contents of the EXE slot and the bubble counter
    always_comb begin
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rf_en_d     = rf_en_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        alu_op_d    = alu_op_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        case (act)
            ACT_BUBBLE: begin
                rs1_d    = '0;
                rs2_d    = '0;
                rd_d     = '0;
                rf_en_d  = 1'b0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                alu_op_d = '0;
                op_a_d   = '0;
                op_b_d   = '0;
                imm_d    = '0;
                valid_d  = 1'b0;
            end
            ACT_CAPTURE: begin
                rs1_d    = ID_RS1;
                rs2_d    = ID_RS2;
                rd_d     = ID_RD;
                rf_en_d  = ID_Reg_File_EN & ID_Valid & (ID_RD != '0);
                mem_rd_d = ID_Mem_Read_EN & ID_Valid;
                mem_wr_d = ID_Mem_Write_EN & ID_Valid;
                alu_op_d = ID_ALU_Op;
                op_a_d   = ID_Operand_A;
                op_b_d   = ID_Operand_B;
                imm_d    = ID_Imm;
                valid_d  = ID_Valid;
            end
            default: ;
        endcase
        if (count_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // EXE slot registers, cleared to a bubble on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rf_en_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            alu_op_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rf_en_q     <= rf_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            alu_op_q    <= alu_op_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ID_EX_RS1               = rs1_q;
    assign ID_EX_RS2               = rs2_q;
    assign WriteBack_reg_EXE_stage = rd_q;
    assign Reg_File_EN_EXE_stage   = rf_en_q;
    assign Mem_Read_EN_EXE_stage   = mem_rd_q;
    assign Mem_Write_EN_EXE_stage  = mem_wr_q;
    assign EX_ALU_Op               = alu_op_q;
    assign EX_Operand_A            = op_a_q;
    assign EX_Operand_B            = op_b_q;
    assign EX_Imm                  = imm_q;
    assign EX_Valid                = valid_q;
    assign Stall_Count             = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: instruction-level model of the EXE slot plus directed scenarios.
module tb_id_ex_hazard_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ID_Valid = 1'b0;
    logic [AW-1:0] ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
    logic          ID_Uses_RS1 = 1'b0, ID_Uses_RS2 = 1'b0;
    logic          ID_Reg_File_EN = 1'b0, ID_Mem_Read_EN = 1'b0, ID_Mem_Write_EN = 1'b0;
    logic [OW-1:0] ID_ALU_Op = '0;
    logic [DW-1:0] ID_Operand_A = '0, ID_Operand_B = '0, ID_Imm = '0;
    logic          Flush_EXE = 1'b0, Stall_In = 1'b0;

    logic [AW-1:0] ID_EX_RS1, ID_EX_RS2, WriteBack_reg_EXE_stage;
    logic          Reg_File_EN_EXE_stage, Mem_Read_EN_EXE_stage, Mem_Write_EN_EXE_stage;
    logic [OW-1:0] EX_ALU_Op;
    logic [DW-1:0] EX_Operand_A, EX_Operand_B, EX_Imm;
    logic          EX_Valid, Stall_IF_ID;
    logic [CW-1:0] Stall_Count;

    id_ex_hazard_reg #(
        .DataWidth(DW), .RegAddrWidth(AW), .AluOpWidth(OW), .CntWidth(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_Uses_RS1(ID_Uses_RS1), .ID_Uses_RS2(ID_Uses_RS2),
        .ID_RD(ID_RD), .ID_Reg_File_EN(ID_Reg_File_EN),
        .ID_Mem_Read_EN(ID_Mem_Read_EN), .ID_Mem_Write_EN(ID_Mem_Write_EN),
        .ID_ALU_Op(ID_ALU_Op), .ID_Operand_A(ID_Operand_A),
        .ID_Operand_B(ID_Operand_B), .ID_Imm(ID_Imm),
        .Flush_EXE(Flush_EXE), .Stall_In(Stall_In),
        .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2),
        .WriteBack_reg_EXE_stage(WriteBack_reg_EXE_stage),
        .Reg_File_EN_EXE_stage(Reg_File_EN_EXE_stage),
        .Mem_Read_EN_EXE_stage(Mem_Read_EN_EXE_stage),
        .Mem_Write_EN_EXE_stage(Mem_Write_EN_EXE_stage),
        .EX_ALU_Op(EX_ALU_Op), .EX_Operand_A(EX_Operand_A),
        .EX_Operand_B(EX_Operand_B), .EX_Imm(EX_Imm),
        .EX_Valid(EX_Valid), .Stall_IF_ID(Stall_IF_ID), .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- instruction-level model of the EXE slot ----------------
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1, rs2, rd;
        logic          wr, ld, st;
        logic [OW-1:0] alu;
        logic [DW-1:0] a, b, imm;
    } slot_t;

    slot_t       m_ex = '0;
    int unsigned m_cnt = 0;

    // ID reads the register a pending load in EXE is about to write
    function automatic bit m_hazard();
        bit reads;
        reads = (ID_Uses_RS1 && ID_RS1 == m_ex.rd) || (ID_Uses_RS2 && ID_RS2 == m_ex.rd);
        return m_ex.valid && m_ex.ld && ID_Valid && m_ex.rd != 0 && reads;
    endfunction

    function automatic slot_t m_from_id();
        slot_t s;
        s.valid = ID_Valid;
        s.rs1 = ID_RS1; s.rs2 = ID_RS2; s.rd = ID_RD;
        s.wr  = ID_Valid && ID_Reg_File_EN && ID_RD != 0;
        s.ld  = ID_Valid && ID_Mem_Read_EN;
        s.st  = ID_Valid && ID_Mem_Write_EN;
        s.alu = ID_ALU_Op; s.a = ID_Operand_A; s.b = ID_Operand_B; s.imm = ID_Imm;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  <= '0;
            m_cnt <= 0;
        end else if (Flush_EXE) begin
            m_ex <= '0;
        end else if (Stall_In) begin
            m_ex <= m_ex;
        end else if (m_hazard()) begin
            m_ex  <= '0;
            m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        end else begin
            m_ex <= m_from_id();
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (!done) begin
            chk("rs1",   64'(ID_EX_RS1),               64'(m_ex.rs1));
            chk("rs2",   64'(ID_EX_RS2),               64'(m_ex.rs2));
            chk("rd",    64'(WriteBack_reg_EXE_stage), 64'(m_ex.rd));
            chk("rf_en", 64'(Reg_File_EN_EXE_stage),   64'(m_ex.wr));
            chk("mem_rd",64'(Mem_Read_EN_EXE_stage),   64'(m_ex.ld));
            chk("mem_wr",64'(Mem_Write_EN_EXE_stage),  64'(m_ex.st));
            chk("alu",   64'(EX_ALU_Op),               64'(m_ex.alu));
            chk("op_a",  64'(EX_Operand_A),            64'(m_ex.a));
            chk("op_b",  64'(EX_Operand_B),            64'(m_ex.b));
            chk("imm",   64'(EX_Imm),                  64'(m_ex.imm));
            chk("valid", 64'(EX_Valid),                64'(m_ex.valid));
            chk("count", 64'(Stall_Count),             64'(m_cnt));
            chk("stall_if_id", 64'(Stall_IF_ID),
                64'(!Flush_EXE && (Stall_In || (rst_n && m_hazard()))));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                          input logic en, input logic ld, input logic st, input logic [DW-1:0] base);
        ID_Valid = v; ID_RS1 = rs1; ID_Uses_RS1 = u1; ID_RS2 = rs2; ID_Uses_RS2 = u2;
        ID_RD = rd; ID_Reg_File_EN = en; ID_Mem_Read_EN = ld; ID_Mem_Write_EN = st;
        ID_ALU_Op = base[3:0]; ID_Operand_A = base + 1; ID_Operand_B = base + 2; ID_Imm = base + 3;
    endtask

    // lw rd, 0(x2)
    task automatic lw(input logic [AW-1:0] rd);
        set_id(1, 5'd2, 1, 5'd0, 0, rd, 1, 1, 0, 32'h1000);
    endtask

    // add rd, rs1, rs2
    task automatic add(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        set_id(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 32'h2000);
    endtask

    initial begin
        // 1: reset, then first valid instruction appears after one edge
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        chk("rst_valid", 64'(EX_Valid), 64'd0);
        chk("rst_count", 64'(Stall_Count), 64'd0);
        rst_n = 1'b1;
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 32'h10);
        cyc();
        chk("t1_rd", 64'(WriteBack_reg_EXE_stage), 64'd5);
        chk("t1_en", 64'(Reg_File_EN_EXE_stage), 64'd1);
        chk("t1_opa", 64'(EX_Operand_A), 64'h11);
        chk("t1_imm", 64'(EX_Imm), 64'h13);

        // 2: lw x5 ; add x6,x5,x7 -> one bubble
        lw(5'd5);
        cyc();
        add(5'd6, 5'd5, 5'd7);
        #1 chk("t2_stall", 64'(Stall_IF_ID), 64'd1);
        cyc();
        chk("t2_bubble", 64'(EX_Valid), 64'd0);
        chk("t2_count", 64'(Stall_Count), 64'd1);
        chk("t2_nostall", 64'(Stall_IF_ID), 64'd0);
        cyc();
        chk("t2_rd", 64'(WriteBack_reg_EXE_stage), 64'd6);
        chk("t2_valid", 64'(EX_Valid), 64'd1);

        // 3: x5 only in an unused RS2 slot; then lw x0 followed by a use of x0
        lw(5'd5);
        cyc();
        set_id(1, 5'd7, 1, 5'd5, 0, 5'd8, 1, 0, 0, 32'h30);
        #1 chk("t3_nouse", 64'(Stall_IF_ID), 64'd0);
        cyc();
        chk("t3_rd", 64'(WriteBack_reg_EXE_stage), 64'd8);
        lw(5'd0);
        cyc();
        chk("t3_x0_en", 64'(Reg_File_EN_EXE_stage), 64'd0);
        add(5'd9, 5'd0, 5'd0);
        #1 chk("t3_x0", 64'(Stall_IF_ID), 64'd0);
        cyc();
        chk("t3_count", 64'(Stall_Count), 64'd1);

        // 4: flush and load-use in the same cycle
        lw(5'd5);
        cyc();
        add(5'd6, 5'd5, 5'd7);
        Flush_EXE = 1'b1; Stall_In = 1'b1;
        #1 chk("t4_stall", 64'(Stall_IF_ID), 64'd0);
        cyc();
        Flush_EXE = 1'b0; Stall_In = 1'b0;
        chk("t4_bubble", 64'(EX_Valid), 64'd0);
        chk("t4_count", 64'(Stall_Count), 64'd1);

        // 5: external stall for 3 cycles with lw x5 in EXE, use waiting in ID
        lw(5'd5);
        cyc();
        add(5'd6, 5'd5, 5'd7);
        Stall_In = 1'b1;
        repeat (3) begin
            cyc();
            chk("t5_hold_rd", 64'(WriteBack_reg_EXE_stage), 64'd5);
            chk("t5_hold_ld", 64'(Mem_Read_EN_EXE_stage), 64'd1);
            chk("t5_hold_cnt", 64'(Stall_Count), 64'd1);
        end
        Stall_In = 1'b0;
        cyc();
        chk("t5_bubble", 64'(EX_Valid), 64'd0);
        chk("t5_count", 64'(Stall_Count), 64'd2);
        cyc();
        chk("t5_rd", 64'(WriteBack_reg_EXE_stage), 64'd6);

        // Reset in the middle of a load-use stall
        lw(5'd5);
        cyc();
        add(5'd6, 5'd5, 5'd7);
        #1 chk("rs_stall", 64'(Stall_IF_ID), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 64'(EX_Valid), 64'd0);
        chk("rs_stall0", 64'(Stall_IF_ID), 64'd0);
        chk("rs_count", 64'(Stall_Count), 64'd0);
        cyc();
        rst_n = 1'b1;

        // 6: write to x0 and invalid instruction gate enables
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 1, 32'h40);
        cyc();
        chk("t6_x0_en", 64'(Reg_File_EN_EXE_stage), 64'd0);
        chk("t6_st", 64'(Mem_Write_EN_EXE_stage), 64'd1);
        chk("t6_valid", 64'(EX_Valid), 64'd1);
        set_id(0, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, 32'h50);
        cyc();
        chk("t6_inv_en", 64'(Reg_File_EN_EXE_stage), 64'd0);
        chk("t6_inv_ld", 64'(Mem_Read_EN_EXE_stage), 64'd0);
        chk("t6_inv_b", 64'(EX_Operand_B), 64'h52);

        // Counter saturation: 9 load-use pairs on a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            lw(5'd5);
            cyc();
            add(5'd6, 5'd5, 5'd7);
            cyc();
            cyc();
        end
        chk("sat_count", 64'(Stall_Count), 64'd7);

        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
